// File: rtl/complex_accumulator_if.sv
// Product-in / frame-sum-out stream bundle for complex_accumulator.
// slave is the accumulator side; master is the producer/consumer side.
interface complex_accumulator_if #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_re;
  logic [31:0]      in_im;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_re;
  logic [ACC_W-1:0] out_im;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_re, in_im, in_last, out_ready,
    output in_ready, out_valid, out_re, out_im, out_cnt, out_ovf
  );

  modport master (
    output in_valid, in_re, in_im, in_last, out_ready,
    input  in_ready, out_valid, out_re, out_im, out_cnt, out_ovf
  );
endinterface

// File: rtl/complex_accumulator.sv
// Frame accumulator for signed complex products; sum held on valid/ready until taken.
// Define CACC_SAT_EN to clamp accumulators on overflow instead of wrapping.
//
// state   | meaning
// ST_ACC  | accepting products, summing into acc_re/acc_im
// ST_HOLD | frame sum presented on out_*, input stalled
module complex_accumulator #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  complex_accumulator_if.slave bus
);
  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, state_nxt;

  logic signed [ACC_W-1:0] acc_re, acc_im;
  logic signed [ACC_W-1:0] ext_re, ext_im;
  logic signed [ACC_W-1:0] sum_re, sum_im;
  logic signed [ACC_W-1:0] upd_re, upd_im;
  logic [CNT_W-1:0]        cnt, cnt_upd;
  logic                    ovf, ovf_re, ovf_im;
  logic [ACC_W-1:0]        res_re, res_im;
  logic [CNT_W-1:0]        res_cnt;
  logic                    res_ovf;
  logic                    accept, xfer;

  assign bus.in_ready  = (state == ST_ACC);
  assign bus.out_valid = (state == ST_HOLD);
  assign bus.out_re    = res_re;
  assign bus.out_im    = res_im;
  assign bus.out_cnt   = res_cnt;
  assign bus.out_ovf   = res_ovf;

  assign accept = bus.in_valid & bus.in_ready;
  assign xfer   = bus.out_valid & bus.out_ready;

  always_comb begin
    state_nxt = state;
    ext_re    = ACC_W'($signed(bus.in_re));
    ext_im    = ACC_W'($signed(bus.in_im));
    sum_re    = acc_re + ext_re;
    sum_im    = acc_im + ext_im;
    // Same-sign operands with a sign change in the result means overflow.
    ovf_re    = (acc_re[ACC_W-1] == ext_re[ACC_W-1]) && (sum_re[ACC_W-1] != acc_re[ACC_W-1]);
    ovf_im    = (acc_im[ACC_W-1] == ext_im[ACC_W-1]) && (sum_im[ACC_W-1] != acc_im[ACC_W-1]);
`ifdef CACC_SAT_EN
    upd_re    = ovf_re ? (acc_re[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_re;
    upd_im    = ovf_im ? (acc_im[ACC_W-1] ? ACC_MIN : ACC_MAX) : sum_im;
`else
    upd_re    = sum_re;
    upd_im    = sum_im;
`endif
    cnt_upd   = (&cnt) ? cnt : cnt + CNT_W'(1);

    case (state)
      ST_ACC:  if (accept && bus.in_last) state_nxt = ST_HOLD;
      ST_HOLD: if (xfer) state_nxt = ST_ACC;
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_ACC;
      acc_re  <= '0;
      acc_im  <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      res_re  <= '0;
      res_im  <= '0;
      res_cnt <= '0;
      res_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (bus.in_last) begin
          // Closing product is included in the published sum.
          res_re  <= upd_re;
          res_im  <= upd_im;
          res_cnt <= cnt_upd;
          res_ovf <= ovf | ovf_re | ovf_im;
          acc_re  <= '0;
          acc_im  <= '0;
          cnt     <= '0;
          ovf     <= 1'b0;
        end else begin
          acc_re  <= upd_re;
          acc_im  <= upd_im;
          cnt     <= cnt_upd;
          ovf     <= ovf | ovf_re | ovf_im;
        end
      end
    end
  end
endmodule
